horner_datapath: RTL
====================

Name: horner_datapath

Overview:
- Parametrised successor to the three-register/three-mux operative block.
- Evaluates s = a·x² + b·x + c with Horner's form: s = ((a·x) + b)·x + c.
- Uses an internal control FSM, a sequential shift-add multiplier and a start/busy/done handshake.
- Sits between the input operand registers and the result display/bus logic. An external controller no longer drives the mux selects.

Parameters:
- W, 16, operand and result width in bits (W ≥ 2). All arithmetic is modulo 2^W.

Ports:
- clk, input, 1, system clock. All state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request an evaluation. Sampled only in IDLE.
- a, input, W, x² coefficient.
- b, input, W, x coefficient.
- c, input, W, constant term.
- x, input, W, evaluation point.
- busy, output, 1, high from the cycle after start is accepted until DONE is left.
- done, output, 1, one-cycle pulse when result becomes valid.
- result, output, W, last completed s. Holds its value between evaluations.

Behaviour:
- Reset: asynchronous. Forces IDLE. busy=0, done=0, result=0; all internal registers (X, H, S, multiplier) cleared. Reset mid-evaluation aborts it and no done is produced.
- States: IDLE, LOAD, MUL1, ADD1, MUL2, ADD2, DONE.
- IDLE: on start=1, go to LOAD. Otherwise stay.
- LOAD (1 cycle): capture a, b, c, x into internal registers. H = a.
- MUL1 (W cycles): H·X through the shift-add multiplier, one multiplier bit per cycle, LSB first. Low W bits go to H.
- ADD1 (1 cycle): H = H + b, truncated to W bits.
- MUL2 (W cycles): H = H·X, truncated.
- ADD2 (1 cycle): S = H + c, truncated.
- DONE (1 cycle): result ← S, done=1. Return to IDLE.
- Latency: start sampled at edge 0 gives done=1 and the new result valid in the cycle after edge 2W+3. For W=16 that is edge 35.
- Throughput: one evaluation per 2W+5 cycles. A new start can be accepted in the IDLE cycle after DONE.
- Inputs are sampled only in LOAD. Changes to a, b, c, x during busy have no effect.
- start while busy is ignored, not queued.
- start held high continuously re-triggers on each IDLE visit.
- busy=1 in LOAD through DONE inclusive. done and busy are both high in DONE.
- Multiplication by 0 and by 1 still takes the full W cycles. There is no early termination.

Optional Feature:
- Macro: HORNER_OVF_EN.
- With the macro defined:
  - Extra output port ovf, 1 bit.
  - An internal sticky flag sets when any MUL step produces a non-zero upper W bits, or when any ADD step produces a carry out of bit W-1.
  - The flag clears in LOAD. It is copied to ovf in DONE and held with result. ovf resets to 0.
- Without the macro: no ovf port and no detection logic. result is still truncated modulo 2^W.

Decomposition:
- Shared header horner_pkg.vh:
  - State encoding as localparams: IDLE=0, LOAD=1, MUL1=2, ADD1=3, MUL2=4, ADD2=5, DONE=6, 3 bits.
  - Default width macro.
- Sub-module shift_add_mul:
  - Parametrised on W.
  - Ports: clk, rst, go, multiplicand, multiplier, prod (2W), fin.
  - Iterative, W cycles.
  - Instantiated once and reused for MUL1 and MUL2.
- The W-bit adder is inline logic.

Test Plan:
- W=16; a=2, b=3, c=5, x=4; start pulse at edge 0 -> done=1 after edge 35 for exactly 1 cycle; result=49; busy low again after edge 36.
- a=0x0100, b=0, c=0, x=0x0100 -> result=0x0000. With HORNER_OVF_EN, ovf=1. Without it, no ovf port exists.
- a=0, b=0xFFFF, c=1, x=1 -> result=0x0000 (wrap-around); ovf=1 when enabled. A following run with a=0, b=0, c=7, x=0 -> result=7, ovf=0.
- During busy: pulse start and change a, b, c, x -> ignored. Result equals the first operand set, and only one done pulse is seen.
- Assert rst at edge 20 of an evaluation -> busy=0, done=0, result=0 immediately (asynchronous). No done follows. A new start after release completes normally.
- result holds 49 for 10 idle cycles after done with inputs toggling -> unchanged.

Source files
------------

// File: rtl/horner_datapath_pkg.sv
// horner_datapath_pkg: state encoding and default operand width for the Horner evaluator.
package horner_datapath_pkg;

  localparam int DEFAULT_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL1 = 3'd2,
    ADD1 = 3'd3,
    MUL2 = 3'd4,
    ADD2 = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/horner_datapath_shift_add_mul.sv
// shift_add_mul: iterative W x W -> 2W multiplier, one multiplier bit per cycle, LSB first.
// go loads the operands; the W steps follow on the next W clock edges, fin marks the last step.
module shift_add_mul
  import horner_datapath_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [2*W-1:0] prod,
  output logic           fin
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (go) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, multiplicand};
      mplier <= multiplier;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (fin)
        run <= 1'b0;
    end
  end

  assign prod = acc;
  assign fin  = run && (cnt == CW'(W - 1));

endmodule

// File: rtl/horner_datapath.sv
// horner_datapath: evaluates s = ((a*x) + b)*x + c modulo 2^W with a start/busy/done handshake.
// Define HORNER_OVF_EN to add the sticky overflow output ovf.
module horner_datapath
  import horner_datapath_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] x,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
`ifdef HORNER_OVF_EN
  ,
  output logic         ovf
`endif
);

  state_t         state, next_state;
  logic [W-1:0]   x_reg, b_reg, c_reg, s_reg, result_q;
  logic [W-1:0]   addend, mul_a, mul_b;
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic           go, fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = MUL1;
      MUL1:    if (fin) next_state = ADD1;
      ADD1:    next_state = MUL2;
      MUL2:    if (fin) next_state = ADD2;
      ADD2:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The new result is shown straight from S during DONE, then held in result_q.
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    go     = (state == LOAD) || (state == ADD1);
    result = (state == DONE) ? s_reg : result_q;
  end

  // H lives in the multiplier's multiplicand register: a in LOAD, H+b in ADD1.
  assign addend = (state == ADD2) ? c_reg : b_reg;
  assign sum    = {1'b0, prod[W-1:0]} + {1'b0, addend};
  assign mul_a  = (state == LOAD) ? a : sum[W-1:0];
  assign mul_b  = (state == LOAD) ? x : x_reg;

  shift_add_mul #(.W(W)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .multiplicand (mul_a),
    .multiplier   (mul_b),
    .prod         (prod),
    .fin          (fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      s_reg    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        LOAD: begin
          x_reg <= x;
          b_reg <= b;
          c_reg <= c;
        end
        ADD2:    s_reg <= sum[W-1:0];
        DONE:    result_q <= s_reg;
        default: ;
      endcase
    end
  end

`ifdef HORNER_OVF_EN
  logic flag, ovf_q;

  // Each ADD step also sees the product just finished, so both checks happen there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        LOAD: flag <= 1'b0;
        ADD1, ADD2:
          if (sum[W] || (prod[2*W-1:W] != '0))
            flag <= 1'b1;
        DONE: ovf_q <= flag;
        default: ;
      endcase
    end
  end

  assign ovf = (state == DONE) ? flag : ovf_q;
`else
  logic unused_ovf_bits;
  assign unused_ovf_bits = ^{prod[2*W-1:W], sum[W]};
`endif

endmodule
